// File: rtl/convolver_3x3_pkg.sv
// convolver_3x3 shared widths and types.
// Pixel/coefficient width follows the PE datapath width.
package convolver_3x3_pkg;
   localparam int WID_PE_BITS  = 16;
   localparam int WID_ACC_BITS = 2 * WID_PE_BITS + 4;
   localparam int ROW_DEPTH    = 256;
   localparam int WID_ROW      = 8;

   typedef logic signed [WID_PE_BITS-1:0]  pix_t;
   typedef logic signed [WID_ACC_BITS-1:0] acc_t;
endpackage

// File: rtl/convolver_3x3_if.sv
// Streaming/control bundle for the 3x3 convolver.
interface convolver_3x3_if;
   import convolver_3x3_pkg::*;

   logic               shifting_line;
   logic               line_buffer_reset;
   logic [WID_ROW-1:0] row_length;
   pix_t               input_line;
   logic               shifting_filter;
   pix_t               input_filter;
   logic               mac_enable;
   acc_t               output_mac;

   modport master (
      output shifting_line, line_buffer_reset, row_length,
      output input_line, shifting_filter, input_filter,
      output mac_enable,
      input  output_mac
   );

   modport slave (
      input  shifting_line, line_buffer_reset, row_length,
      input  input_line, shifting_filter, input_filter,
      input  mac_enable,
      output output_mac
   );
endinterface

// File: rtl/convolver_3x3_row_delay.sv
// Circular row-delay line: len-deep, advances on i_en.
module row_delay #(
   parameter  int DW    = 16,
   parameter  int DEPTH = 256,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [PTR_W-1:0] i_len,
   input  logic [DW-1:0]    i_din,
   output logic [DW-1:0]    o_dout
);
   logic [DW-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_last;

   assign w_last = i_len - PTR_W'(1);
   assign o_dout = r_mem[r_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_en) begin
         r_ptr <= (r_ptr == w_last) ? '0 : r_ptr + PTR_W'(1);
      end
   end

   // Read-before-write on one pointer gives exactly len cycles of delay.
   always_ff @(posedge clk) begin
      if (i_en && !i_clr) begin
         r_mem[r_ptr] <= i_din;
      end
   end
endmodule

// File: rtl/convolver_3x3.sv
// Streaming 3x3 cross-correlation: line buffer, window, 3-stage MAC.
module convolver_3x3
   import convolver_3x3_pkg::*;
#(
   parameter int DATA_W  = WID_PE_BITS,
   parameter int ACC_W   = WID_ACC_BITS,
   parameter int MAX_ROW = ROW_DEPTH
) (
   input logic            clk,
   input logic            rst,
   convolver_3x3_if.slave bus
);
   localparam int PW = 2 * DATA_W;

   logic signed [DATA_W-1:0] r_coef [9];
   logic signed [DATA_W-1:0] r_in;
   logic signed [DATA_W-1:0] r_win [3][3];
   logic signed [DATA_W-1:0] w_line_2;
   logic signed [DATA_W-1:0] w_out_line_3;
   logic signed [PW-1:0]     w_prod [9];
   logic signed [PW-1:0]     r_prod [9];
   logic signed [ACC_W-1:0]  r_row [3];
   logic signed [ACC_W-1:0]  r_acc;
   logic                     w_shift;

   assign w_shift = bus.shifting_line & ~bus.line_buffer_reset;

   // New coefficient enters at c8; the first one loaded ends at c0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) r_coef[i] <= '0;
      end else if (bus.shifting_filter) begin
         for (int i = 0; i < 8; i++) r_coef[i] <= r_coef[i+1];
         r_coef[8] <= bus.input_filter;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end else if (bus.line_buffer_reset) begin
         r_in <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end else if (bus.shifting_line) begin
         r_in <= bus.input_line;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++) r_win[r][c] <= r_win[r][c+1];
         r_win[2][2] <= r_in;
         r_win[1][2] <= w_line_2;
         r_win[0][2] <= w_out_line_3;
      end
   end

   row_delay #(.DW(DATA_W), .DEPTH(MAX_ROW)) u_dly_a (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (bus.line_buffer_reset),
      .i_en   (w_shift),
      .i_len  (bus.row_length),
      .i_din  (r_win[2][0]),
      .o_dout (w_line_2)
   );

   row_delay #(.DW(DATA_W), .DEPTH(MAX_ROW)) u_dly_b (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (bus.line_buffer_reset),
      .i_en   (w_shift),
      .i_len  (bus.row_length),
      .i_din  (r_win[1][0]),
      .o_dout (w_out_line_3)
   );

   always_comb begin
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w_prod[3*r+c] = PW'(r_coef[3*r+c]) * PW'(r_win[r][c]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) r_prod[i] <= '0;
         for (int r = 0; r < 3; r++) r_row[r] <= '0;
         r_acc <= '0;
      end else begin
         for (int i = 0; i < 9; i++)
            r_prod[i] <= bus.mac_enable ? w_prod[i] : '0;
         for (int r = 0; r < 3; r++)
            r_row[r] <= ACC_W'(r_prod[3*r])
                      + ACC_W'(r_prod[3*r+1])
                      + ACC_W'(r_prod[3*r+2]);
         r_acc <= r_row[0] + r_row[1] + r_row[2];
      end
   end

   assign bus.output_mac = r_acc;
endmodule

// File: tb/tb_convolver_3x3.sv
// Randomized bench for convolver_3x3 against a pixel-history model.
module tb_convolver_3x3;
   import convolver_3x3_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   convolver_3x3_if bus();

   convolver_3x3 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [35:0] got,
                      input logic [35:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Model: the window is the last 2W+3 pixels pushed, W apart per row.
   int     hist[$];
   int     pin;
   int     cf[9];
   int     mw;
   int     cur_rl;
   longint p1, p2, ex;
   bit     k1, k2, ek;

   task automatic model_reset();
      hist.delete();
      pin = 0;
      foreach (cf[i]) cf[i] = 0;
      p1 = 0; p2 = 0; ex = 0;
      k1 = 1; k2 = 1; ek = 1;
      mw = int'(bus.row_length) + 3;
   endtask

   task automatic model_step();
      longint s;
      bit     sk;
      int     n;
      if (!rst) begin
         model_reset();
         return;
      end
      s  = 0;
      sk = 1;
      n  = hist.size();
      if (bus.mac_enable) begin
         if (n >= 2 * mw + 3) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += longint'(cf[3*i+j])
                     * longint'(hist[n-1-(2-j)-(2-i)*mw]);
         end else begin
            sk = 0;
         end
      end
      ex = p2; ek = k2;
      p2 = p1; k2 = k1;
      p1 = s;  k1 = sk;
      if (bus.line_buffer_reset) begin
         hist.delete();
         pin = 0;
         mw  = int'(bus.row_length) + 3;
      end else if (bus.shifting_line) begin
         hist.push_back(pin);
         pin = int'(bus.input_line);
         while (hist.size() > 2 * mw + 3) void'(hist.pop_front());
      end
      if (bus.shifting_filter) begin
         for (int i = 0; i < 8; i++) cf[i] = cf[i+1];
         cf[8] = int'(bus.input_filter);
      end
   endtask

   // One cycle: check previous edge's result, drive, advance model.
   task automatic cyc(input bit sl, input int px, input bit sf,
                      input int fv, input bit me, input bit lbr);
      @(negedge clk);
      if (ek) chk("mac", bus.output_mac, ex[35:0]);
      bus.shifting_line     = sl;
      bus.input_line        = px[15:0];
      bus.shifting_filter   = sf;
      bus.input_filter      = fv[15:0];
      bus.mac_enable        = me;
      bus.line_buffer_reset = lbr;
      bus.row_length        = 8'(cur_rl);
      model_step();
   endtask

   int idf[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
   int nz, fz;

   initial begin
      cur_rl                = 27;
      bus.shifting_line     = 1'b0;
      bus.line_buffer_reset = 1'b0;
      bus.row_length        = 8'(cur_rl);
      bus.input_line        = '0;
      bus.shifting_filter   = 1'b0;
      bus.input_filter      = '0;
      bus.mac_enable        = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_out", bus.output_mac, 36'h0);
      rst = 1'b1;

      for (int k = 0; k < 9; k++) cyc(0, 0, 1, idf[k], 1, 0);
      for (int k = 0; k < 180; k++) begin
         cyc(1, (k / 30) * 30 + (k % 30), 0, 0, 1, 0);
         if (k == 67) chk("id_w30", bus.output_mac, 36'd31);
      end

      for (int k = 0; k < 100; k++) begin
         cyc(1, 100, k < 9, 1, 1, 0);
         if (k == 90) chk("ones", bus.output_mac, 36'd900);
      end

      for (int k = 0; k < 100; k++) begin
         cyc(1, -32768, k < 9, -32768, 1, 0);
         if (k == 90) chk("minneg", bus.output_mac, 36'h240000000);
      end

      nz = 0;
      fz = -1;
      for (int k = 0; k < 30; k++) begin
         cyc(1, -32768, 0, 0, !(k >= 10 && k < 15), 0);
         if (bus.output_mac == '0) begin
            nz++;
            if (fz < 0) fz = k;
         end
      end
      chk("gate_cnt", 36'(nz), 36'd5);
      chk("gate_first", 36'(fz), 36'd13);

      cur_rl = 7;
      cyc(0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 40; k++) begin
         cyc(1, (k / 10) * 10 + (k % 10), k < 9, k < 9 ? idf[k] : 0, 1, 0);
         if (k == 27) chk("id_w10", bus.output_mac, 36'd11);
      end

      for (int rnd = 0; rnd < 5; rnd++) begin
         cur_rl = $urandom_range(1, 37);
         cyc(0, 0, 0, 0, 1, 1);
         for (int k = 0; k < 300; k++) begin
            if (rnd == 2 && k == 150) begin
               rst = 1'b0;
               model_reset();
               #1;
               chk("rst_async", bus.output_mac, 36'h0);
               cyc(1, 0, 0, 0, 1, 0);
               rst = 1'b1;
            end
            cyc(($urandom % 4) != 0,
                int'($urandom_range(0, 65535)),
                ($urandom % 8) == 0,
                int'($urandom_range(0, 65535)),
                ($urandom % 6) != 0,
                ($urandom % 150) == 0);
         end
      end

      cyc(0, 0, 0, 0, 1, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/convolver_3x3.md
# convolver_3x3

Streaming 3×3 convolution engine for one processing element of the inference accelerator. Image pixels arrive one per clock in raster order and pass through an internal line buffer that forms a sliding 3×3 window. Nine filter coefficients are shifted in serially. A pipelined multiply-accumulate produces one 36-bit result per clock.

## Interface
Parameters:
- DATA_W, 16: pixel and coefficient width (the codebase's `WID_PE_BITS`).
- ACC_W, 36: result width, equal to 2·DATA_W+4.
- MAX_ROW, 256: depth of each row-delay memory.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- shifting_line  in  1  advance the line buffer by one pixel this cycle.
- line_buffer_reset  in  1  synchronous clear of the input register, line buffer and window; has priority over shifting_line.
- row_length  in  8  image width W minus 3 (W=30 → 27); static while streaming.
- input_line  in  16  pixel input, signed two's complement.
- shifting_filter  in  1  shift input_filter into the coefficient register this cycle.
- input_filter  in  16  coefficient input, signed.
- mac_enable  in  1  gate for MAC stage 1.
- output_mac  out  36  convolution result, signed.

## Operation
- **Coefficient register:** 9×16-bit shift chain. On shifting_filter=1 the chain shifts and input_filter enters. After 9 shifts, the first-loaded value is c0 and the last is c8. The chain holds its value otherwise.
- **Pixel input register:** captures input_line when shifting_line=1.
- **Line buffer and window.** The window has three rows of 3 registers each (top, mid, bot). Between rows there are two delay lines, each row_length deep, so each row path totals W.
  - The input register feeds bot[2]. bot[0] feeds delay line A, whose output feeds mid[2]. mid[0] feeds delay line B, whose output feeds top[2].
  - Everything advances only when shifting_line=1.
  - The output of delay line B is exposed internally as out_line_3.
  - Delay lines are circular buffers over a MAX_ROW-entry array, with read/write pointers wrapping at row_length.
- **Result:** output = Σ c[3i+j]·win[i][j], where i=0 is the top row and j=0 is the oldest column. This is cross-correlation: out(r,c) = Σ c[3i+j]·img[r+i][c+j].
- **Arithmetic:** 16×16 signed products (32 bits), summed with sign extension to 36 bits. No saturation and no overflow.
- **MAC pipeline:**
  - S1 registers the 9 products, or zeros when mac_enable=0.
  - S2 registers three row sums.
  - S3 registers the total into output_mac.
  - S2 and S3 always advance.
- **Output stream per row:** each image row yields W window positions. The first W−2 are valid. The final 2 straddle a row boundary and are discarded downstream.

## Timing
- Reset (rst=0) clears every register, delay memory pointer and output_mac to 0.
- line_buffer_reset=1 zeroes the input register, window and pointers. Memory contents need not be cleared, because the pointers restart.
- A pixel sampled at edge E enters bot[2] at E+1.
- Window (0,0) is complete one edge after pixel 2W+2 is sampled.
- output_mac reflects a window 4 edges after the window's last pixel is sampled.
- With streaming starting at edge 1 and W=30: out(0,0) is visible after edge 67, provided mac_enable=1 from edge 65.
- Deasserting mac_enable forces output_mac to 0 three edges later.
- Filter and image loading may overlap. Coefficient changes appear in the result at the next S1 capture.
- shifting_line=0 mid-row freezes the window. The MAC keeps recomputing the held window.

## Structure
- Shared package: DATA_W/ACC_W constants (WID_PE_BITS) and a signed pixel typedef.
- One natural sub-module, `row_delay`: a parameterised circular delay line with length input and enable. It is instantiated twice.

## Test plan
- **Reset:** rst=0 mid-stream → output_mac=0 immediately. After release, the first valid result follows the normal latency.
- **Identity filter:** only c4=1, W=30 (row_length=27), img[r][c]=r·30+c → out(r,c)=img[r+1][c+1]; out(0,0)=31 after edge 67. The 2 straddling outputs per row are ignored.
- **All-ones filter:** all-ones filter with constant pixel 100 → every valid output is 900.
- **Sign and width:** all pixels −32768, all coefficients −32768 → output_mac = 9·2³⁰ = 0x240000000, with no overflow.
- **Gating:** mac_enable dropped for 5 cycles → output_mac=0 for exactly 5 results starting 3 edges later.
- **Width change:** line_buffer_reset, then W=10 (row_length=7) with the identity filter → out(0,0)=img[1][1], visible 4 edges after pixel 22 is sampled.
